// File: rtl/bram_req_rsp_master_if.sv
// BramPort: BRAM master/slave bundle with clock, reset, enable, address, byte strobes and data
interface BramPort #(
  parameter int ADDR_BITW = 32,
  parameter int DATA_BITW = 32
);
  logic                   Clk_C;
  logic                   Rst_R;
  logic                   En_S;
  logic [ADDR_BITW-1:0]   Addr_S;
  logic [DATA_BITW/8-1:0] WrEn_S;
  logic [DATA_BITW-1:0]   Wr_D;
  logic [DATA_BITW-1:0]   Rd_D;
  modport Master (output Clk_C, Rst_R, En_S, Addr_S, WrEn_S, Wr_D, input Rd_D);
  modport Slave (input Clk_C, Rst_R, En_S, Addr_S, WrEn_S, Wr_D, output Rd_D);
endinterface

// File: rtl/bram_req_rsp_master.sv
// bram_req_rsp_master: request stream to BRAM master accesses; reads return through a
// credit-limited response FIFO so backpressure never drops BRAM read data.
module bram_req_rsp_master #(
  parameter int ADDR_BITW = 32,
  parameter int DATA_BITW = 32,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                   Clk_C,
  input  logic                   Rst_R,
  input  logic                   ReqValid_S,
  output logic                   ReqReady_S,
  input  logic [ADDR_BITW-1:0]   ReqAddr_S,
  input  logic [DATA_BITW/8-1:0] ReqWrEn_S,
  input  logic [DATA_BITW-1:0]   ReqWr_D,
  output logic                   RspValid_S,
  input  logic                   RspReady_S,
  output logic [DATA_BITW-1:0]   Rsp_D,
  BramPort.Master                ToBram_PM
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  logic                 w_wr, w_acc, w_rd_acc, w_push, w_pop;
  logic [CW-1:0]        r_cred, r_cnt;
  logic [PW-1:0]        r_wp, r_rp;
  logic [RD_LAT-1:0]    r_pipe;
  logic [DATA_BITW-1:0] r_mem [RSP_DEPTH];
  assign w_wr       = |ReqWrEn_S;
  assign ReqReady_S = !Rst_R && (w_wr || r_cred != '0);
  assign w_acc      = ReqValid_S && ReqReady_S;
  assign w_rd_acc   = w_acc && !w_wr;
  assign w_push     = r_pipe[RD_LAT-1];
  assign RspValid_S = r_cnt != '0;
  assign w_pop      = RspValid_S && RspReady_S;
  assign Rsp_D      = RspValid_S ? r_mem[r_rp] : '0;
  assign ToBram_PM.Clk_C  = Clk_C;
  assign ToBram_PM.Rst_R  = Rst_R;
  assign ToBram_PM.En_S   = w_acc;
  assign ToBram_PM.Addr_S = ReqAddr_S;
  assign ToBram_PM.WrEn_S = w_acc ? ReqWrEn_S : '0;
  assign ToBram_PM.Wr_D   = ReqWr_D;
  // Credits reserve a FIFO slot at accept time, covering reads still in the BRAM pipe.
  always_ff @(posedge Clk_C or posedge Rst_R) begin
    if (Rst_R) begin
      r_cred <= CW'(RSP_DEPTH);
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_pipe <= '0;
    end else begin
      r_cred <= r_cred + CW'(w_pop) - CW'(w_rd_acc);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_pipe <= (r_pipe << 1) | RD_LAT'(w_rd_acc);
      if (w_push) r_wp <= (r_wp == PW'(RSP_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= (r_rp == PW'(RSP_DEPTH - 1)) ? '0 : r_rp + 1'b1;
    end
  end
  always_ff @(posedge Clk_C) if (w_push) r_mem[r_wp] <= ToBram_PM.Rd_D;
  a_depth: assert property (@(posedge Clk_C) RSP_DEPTH >= RD_LAT + 1)
    else $fatal(1, "RSP_DEPTH must be at least RD_LAT+1");
  a_ovf: assert property (@(posedge Clk_C) disable iff (Rst_R)
    !(w_push && !w_pop && r_cnt == CW'(RSP_DEPTH)))
    else $fatal(1, "response FIFO overflow");
endmodule

// File: tb/tb_bram_req_rsp_master.sv
// tb_bram_req_rsp_master: directed scenarios plus random traffic against a queue/array reference model
module tb_bram_req_rsp_master;
  typedef struct {logic [31:0] d; int c;} ent_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        vld = 1'b0, rdy, rsp_vld, rrdy = 1'b0;
  logic [31:0] addr = '0, wdat = '0, rsp_d, last = '0;
  logic [3:0]  wen = '0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [16];
  ent_t        q[$];
  int          n_vec = 0, n_bad = 0, cyc = 0, n_acc;
  logic        last_acc;
  BramPort #(.ADDR_BITW(32), .DATA_BITW(32)) bram ();
  bram_req_rsp_master #(.ADDR_BITW(32), .DATA_BITW(32), .RD_LAT(1), .RSP_DEPTH(4)) dut (
    .Clk_C(clk), .Rst_R(rst), .ReqValid_S(vld), .ReqReady_S(rdy), .ReqAddr_S(addr),
    .ReqWrEn_S(wen), .ReqWr_D(wdat), .RspValid_S(rsp_vld), .RspReady_S(rrdy), .Rsp_D(rsp_d),
    .ToBram_PM(bram));
  always #5 clk = ~clk;
  // BRAM with one cycle of read latency
  always @(posedge clk) if (bram.En_S) begin
    for (int b = 0; b < 4; b++)
      if (bram.WrEn_S[b]) mem[bram.Addr_S[9:2]][8*b +: 8] <= bram.Wr_D[8*b +: 8];
    bram.Rd_D <= mem[bram.Addr_S[9:2]];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] d, input logic rr);
    logic acc, pop, hv;
    @(negedge clk);
    vld = v; addr = a; wen = we; wdat = d; rrdy = rr;
    #1;
    acc = v && rdy;
    pop = rsp_vld && rr;
    hv  = q.size() > 0 && q[0].c <= cyc;
    if (v) chk("req_ready", rdy, 32'((we != 0) || q.size() < 4));
    chk("bram_en", bram.En_S, 32'(acc));
    chk("bram_wren", bram.WrEn_S, acc ? we : 4'h0);
    if (acc) chk("bram_addr", bram.Addr_S, a);
    if (acc && we != 0) chk("bram_wr", bram.Wr_D, d);
    chk("rsp_valid", rsp_vld, 32'(hv));
    if (hv) chk("rsp_data", rsp_d, q[0].d);
    if (pop && q.size() > 0) begin
      last = rsp_d;
      void'(q.pop_front());
    end
    if (acc && we == 0) q.push_back(ent_t'{ref_mem[a[5:2]], cyc + 2});
    if (acc && we != 0)
      for (int b = 0; b < 4; b++) if (we[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    last_acc = acc;
    cyc++;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    #3;
    chk("rst_req_ready", rdy, 0);
    chk("rst_rsp_valid", rsp_vld, 0);
    chk("rst_rsp_data", rsp_d, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), 4'hF, $urandom, 1'b1);
    // write then read back
    step(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
    step(1'b1, 32'h10, 4'h0, 32'h0, 1'b1);
    drain();
    chk("t1_data", last, 32'hDEADBEEF);
    // back-to-back reads with no backpressure
    for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b1);
    drain();
    // credit exhaustion under backpressure
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b0);
      n_acc += int'(last_acc);
    end
    chk("t3_accepted", n_acc, 4);
    step(1'b1, 32'h3C, 4'hF, 32'hCAFEF00D, 1'b0);
    chk("t3_write_acc", last_acc, 1);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    step(1'b1, 32'h3C, 4'h0, 32'h0, 1'b0);
    chk("t3_read_after_pop", last_acc, 1);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    // full FIFO, then concurrent pop and read across the pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b1);
    drain();
    // async reset with reads buffered and in flight
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b0);
    vld = 1'b0; wen = 4'hF;
    rst = 1'b1;
    #1;
    chk("t5_rsp_valid", rsp_vld, 0);
    chk("t5_rsp_data", rsp_d, 0);
    chk("t5_req_ready", rdy, 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b0);
      n_acc += int'(last_acc);
    end
    chk("t5_credits", n_acc, 4);
    repeat (3) step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    drain();
    // partial byte write
    step(1'b1, 32'h20, 4'hF, 32'h12345678, 1'b1);
    step(1'b1, 32'h20, 4'h3, 32'h0000AAAA, 1'b1);
    step(1'b1, 32'h20, 4'h0, 32'h0, 1'b1);
    drain();
    chk("t6_partial", last, 32'h1234AAAA);
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 32'({$urandom_range(0, 15), 2'b00}),
           ($urandom % 2) ? 4'($urandom) : 4'h0, $urandom, ($urandom % 4) != 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
